// File: rtl/c17_stress_array.sv
// c17_stress_array: NUM_CORES registered ISCAS85 c17 cores driven by a run
// controller, with per-core toggle counters and a sticky golden compare.
module c17_cell (
  input  logic [4:0] a,
  output logic [1:0] y
);
  logic n1, n2, n3, n6, n7;
  logic n10, n11, n16, n19;

  assign {n7, n6, n3, n2, n1} = a;
  assign n10 = ~(n1 & n3);
  assign n11 = ~(n3 & n6);
  assign n16 = ~(n2 & n11);
  assign n19 = ~(n11 & n7);
  assign y   = {~(n16 & n19), ~(n10 & n16)};
endmodule

module c17_stress_array #(
  parameter int          NUM_CORES = 4,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          SEL_W     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       run_len,
  input  logic [NUM_CORES-1:0]   core_en,
  input  logic [5*NUM_CORES-1:0] ext_in,
  input  logic [SEL_W-1:0]       cnt_sel,
  output logic [2*NUM_CORES-1:0] out_q,
  output logic [NUM_CORES-1:0]   mismatch,
  output logic [CNT_W-1:0]       cnt_rd,
  output logic                   busy,
  output logic                   done
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] rem;
  logic [15:0]      lfsr, lfsr_nxt;
  logic             go;
  logic [CNT_W-1:0] cnt_a [NUM_CORES];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    go        = 1'b0;
    unique case (state)
      IDLE: begin
        go = start;
        if (start)
          state_nxt = (run_len == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (rem == CNT_W'(1))
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Galois form of x^16+x^14+x^13+x^11+1
  assign lfsr_nxt = {1'b0, lfsr[15:1]}
                  ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mode_q <= 2'b00;
      rem    <= '0;
      lfsr   <= SEED;
    end else begin
      state <= state_nxt;
      if (go) begin
        mode_q <= mode;
        rem    <= run_len;
        lfsr   <= SEED;
      end else if (busy) begin
        rem <= rem - CNT_W'(1);
        if (mode_q == 2'b10)
          lfsr <= lfsr_nxt;
      end
    end
  end

  for (genvar k = 0; k < NUM_CORES; k++) begin : g_core
    localparam int ROT = (5 * k) % 16;

    logic [4:0]       in_q, lfsr_rot;
    logic [1:0]       y, gold_nxt, gold_q, oq, cur, tog;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   sum;
    logic             mis;

    c17_cell u_cell (
      .a(in_q),
      .y(y)
    );

    always_comb begin
      lfsr_rot = '0;
      for (int i = 0; i < 5; i++)
        lfsr_rot[i] = lfsr[4'((i + ROT) % 16)];
    end

    // Sum-of-products reference, independent of the NAND netlist
    assign gold_nxt[0] = (in_q[0] & in_q[2])
                       | (in_q[1] & ~(in_q[2] & in_q[3]));
    assign gold_nxt[1] = ~(in_q[2] & in_q[3])
                       & (in_q[1] | in_q[4]);

    assign cur = out_q[2*k +: 2];
    assign tog = y ^ cur;
    assign sum = {1'b0, cnt}
               + (CNT_W+1)'(tog[0])
               + (CNT_W+1)'(tog[1]);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_q   <= '0;
        oq     <= '0;
        gold_q <= '0;
        cnt    <= '0;
        mis    <= 1'b0;
      end else begin
        oq     <= y;
        gold_q <= gold_nxt;
        if (busy && core_en[k]) begin
          case (mode_q)
            2'b01:   in_q <= ext_in[5*k +: 5];
            2'b10:   in_q <= lfsr_rot;
            default: ;
          endcase
        end
        if (go) begin
          cnt <= '0;
          mis <= 1'b0;
        end else if (busy) begin
          cnt <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
          if (gold_q != cur)
            mis <= 1'b1;
        end
      end
    end

    assign out_q[2*k +: 2] = oq;
    assign mismatch[k]     = mis;
    assign cnt_a[k]        = cnt;
  end

  always_comb begin
    cnt_rd = '0;
    for (int k = 0; k < NUM_CORES; k++)
      if (cnt_sel == SEL_W'(k))
        cnt_rd = cnt_a[k];
  end
endmodule

// File: tb/tb_c17_stress_array.sv
// Bench for c17_stress_array: cycle model for a 4-core/16-bit array
// plus directed checks on a 4-bit-counter instance.
module tb_c17_stress_array;
  logic        clk;
  logic        rst, start;
  logic [1:0]  mode;
  logic [15:0] run_len;
  logic [3:0]  core_en;
  logic [19:0] ext_in;
  logic [1:0]  cnt_sel;
  logic [7:0]  out_q;
  logic [3:0]  mismatch;
  logic [15:0] cnt_rd;
  logic        busy, done;

  logic        rst2, start2;
  logic [1:0]  mode2;
  logic [3:0]  run_len2;
  logic [3:0]  core_en2;
  logic [19:0] ext2;
  logic [1:0]  cnt_sel2;
  logic [7:0]  out_q2;
  logic [3:0]  mismatch2;
  logic [3:0]  cnt_rd2;
  logic        busy2, done2;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 0;
  int busy_cnt = 0;

  c17_stress_array #(.NUM_CORES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .run_len(run_len), .core_en(core_en), .ext_in(ext_in),
    .cnt_sel(cnt_sel), .out_q(out_q), .mismatch(mismatch),
    .cnt_rd(cnt_rd), .busy(busy), .done(done)
  );

  c17_stress_array #(.NUM_CORES(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst2), .start(start2), .mode(mode2),
    .run_len(run_len2), .core_en(core_en2), .ext_in(ext2),
    .cnt_sel(cnt_sel2), .out_q(out_q2), .mismatch(mismatch2),
    .cnt_rd(cnt_rd2), .busy(busy2), .done(done2)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic bit [1:0] c17f(input bit [4:0] v);
    bit n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n7, n6, n3, n2, n1} = v;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n16 & n19), ~(n10 & n16)};
  endfunction

  function automatic bit [4:0] rotf(input bit [15:0] l, input int k);
    bit [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = l[(i + 5 * k) % 16];
    return r;
  endfunction

  // Cycle model of dut
  bit [4:0]  m_in [4];
  bit [1:0]  m_out [4];
  int        m_cnt [4];
  bit [3:0]  m_mis;
  bit        m_busy, m_done;
  int        m_left;
  bit [1:0]  m_mode;
  bit [15:0] m_lfsr;
  bit [1:0]  m_nx;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_left = 0; m_mode = 0;
      m_lfsr = 16'hACE1; m_mis = 0;
      for (int k = 0; k < 4; k++) begin
        m_in[k] = 0; m_out[k] = 0; m_cnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        m_nx = c17f(m_in[k]);
        if (m_busy) begin
          m_cnt[k] += $countones(m_nx ^ m_out[k]);
          if (m_cnt[k] > 65535) m_cnt[k] = 65535;
        end
        if (m_busy && core_en[k]) begin
          if (m_mode == 2'b01) m_in[k] = ext_in[5*k +: 5];
          else if (m_mode == 2'b10) m_in[k] = rotf(m_lfsr, k);
        end
        m_out[k] = m_nx;
      end
      if (m_busy && m_mode == 2'b10)
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      if (m_done) m_done = 0;
      else if (m_busy) begin
        m_left--;
        if (m_left == 0) begin m_busy = 0; m_done = 1; end
      end else if (start) begin
        m_mode = mode; m_lfsr = 16'hACE1; m_mis = 0;
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        if (run_len == 0) m_done = 1;
        else begin m_busy = 1; m_left = int'(run_len); end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_q", out_q, {m_out[3], m_out[2], m_out[1], m_out[0]});
      chk("mismatch", mismatch, m_mis);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("cnt_rd", cnt_rd, m_cnt[cnt_sel]);
    end
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit [1:0] m, input bit [15:0] len);
    mode = m; run_len = len; start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 500) begin tick(); n++; end
    chk(nm, done, 1);
    tick();
  endtask

  initial begin
    rst = 1; start = 0; mode = 0; run_len = 0; core_en = 0;
    ext_in = 0; cnt_sel = 0;
    rst2 = 1; start2 = 0; mode2 = 0; run_len2 = 0; core_en2 = 0;
    ext2 = 0; cnt_sel2 = 0;
    repeat (3) tick();
    rst = 0; rst2 = 0;
    chk("t1_out", out_q, 0);
    chk("t1_mis", mismatch, 0);
    chk("t1_cnt", cnt_rd, 0);
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_lfsr", dut.lfsr, 16'hACE1);
    chk_on = 1;
    tick();

    core_en = 4'hF;
    ext_in = {4{5'h1F}};
    start_run(2'b01, 4);
    tick(); tick();
    chk("t2_ones", out_q, 8'h55);
    ext_in = 0;
    tick(); tick();
    chk("t2_done", done, 1);
    chk("t2_zero", out_q, 8'h00);
    tick();
    chk("t2_done_off", done, 0);

    core_en = 4'b0101;
    start_run(2'b10, 100);
    tick(); tick();
    chk("t3_lfsr_pin", out_q, 8'h30);
    wait_done("t3_end");
    for (int k = 0; k < 4; k++) begin
      cnt_sel = 2'(k);
      #1;
      if (k == 0 || k == 2) chk("t3_cnt_pos", cnt_rd != 0, 1);
      else chk("t3_cnt_zero", cnt_rd, 0);
    end
    chk("t3_frozen", out_q[7:6] == 2'b00 && out_q[3:2] == 2'b00, 1);
    chk("t3_mis", mismatch, 0);

    core_en = 4'hF;
    ext_in = {4{5'h0A}};
    start_run(2'b01, 2);
    wait_done("t4_load");
    chk("t4_vec", out_q, 8'hFF);
    start_run(2'b11, 50);
    wait_done("t4_end");
    chk("t4_hold", out_q, 8'hFF);
    for (int k = 0; k < 4; k++) begin
      cnt_sel = 2'(k);
      #1;
      chk("t4_cnt_zero", cnt_rd, 0);
    end

    busy_cnt = 0;
    start_run(2'b01, 0);
    chk("t5_zero_done", done, 1);
    chk("t5_zero_busy", busy, 0);
    tick();
    chk("t5_zero_off", done, 0);
    chk("t5_zero_nobusy", busy_cnt, 0);
    busy_cnt = 0;
    start_run(2'b01, 10);
    tick(); tick();
    mode = 2'b00; run_len = 3; start = 1;
    tick();
    start = 0;
    wait_done("t5_ign_end");
    chk("t5_busy_len", busy_cnt, 10);

    core_en2 = 4'hF;
    mode2 = 2'b01; run_len2 = 15; start2 = 1;
    tick();
    start2 = 0;
    for (int i = 0; i < 20; i++) begin
      ext2 = (i % 2 == 0) ? {4{5'h02}} : 20'h0;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      cnt_sel2 = 2'(k);
      #1;
      chk("t6_sat", cnt_rd2, 4'hF);
    end

    ext2 = {4{5'h02}};
    start2 = 1;
    tick();
    start2 = 0;
    repeat (3) tick();
    chk("t6_pre_out", out_q2, 8'hFF);
    chk("t6_pre_mis", mismatch2, 0);
    force dut2.out_q = 8'hEF;
    tick();
    release dut2.out_q;
    chk("t6_mis_set", mismatch2, 4'b0100);
    tick(); tick();
    chk("t6_mis_sticky", mismatch2, 4'b0100);
    chk("t6_busy", busy2, 1);
    rst2 = 1;
    #1;
    chk("t6_rst_mis", mismatch2, 0);
    chk("t6_rst_busy", busy2, 0);
    chk("t6_rst_out", out_q2, 0);
    chk("t6_rst_cnt", cnt_rd2, 0);
    tick();
    rst2 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_done", done2, 0);
    end

    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
